uart_core: RTL and testbench

UART_CORE -- requirements
Module: uart_core

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_sync_fifo.sv | 49 ++++
 rtl/uart_core.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_uart_core.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX/RX state encodings and the bit-period floor.
// The PARITY states and parity helper exist only when UART_PARITY_EN is defined.
package uart_pkg;

    localparam int MIN_CLOCKS_PER_PULSE = 4;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} txState_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rxState_t;

    function automatic logic evenParity(input logic [8:0] word);
        return ^word;
    endfunction
`else
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} txState_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
`endif

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with an extra pointer bit to tell full from empty.
// A push into a full FIFO is taken only when a pop frees a slot in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    logic             w_doPush;
    logic             w_doPop;

    assign o_empty  = (r_wrPtr == r_rdPtr);
    assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);
    assign o_data   = r_mem[r_rdPtr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr[AW-1:0]] <= i_data;
                r_wrPtr <= r_wrPtr + (AW+1)'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_core.sv
// FIFO-buffered UART: transmitter plus mid-bit-sampling receiver.
// Define UART_PARITY_EN to add an even-parity bit on TX and a parity check on RX.
module uart_core
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = 5208,
    parameter int DATA_BITS        = 8,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun
);

    localparam int CPP   = (CLOCKS_PER_PULSE < MIN_CLOCKS_PER_PULSE) ? MIN_CLOCKS_PER_PULSE : CLOCKS_PER_PULSE;
    localparam int CNT_W = $clog2(CPP);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPP - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPP / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 r_outOfReset;
    logic                 w_txFull;
    logic                 w_txEmpty;
    logic                 w_txPop;
    logic [DATA_BITS-1:0] w_txHead;
    txState_t             r_txState;
    logic [CNT_W-1:0]     r_txCnt;
    logic [BIT_W-1:0]     r_txBit;
    logic [DATA_BITS-1:0] r_txShift;
    logic                 r_tx;

    logic                 r_rxMeta;
    logic                 r_rxSync;
    logic                 r_rxPrev;
    rxState_t             r_rxState;
    logic [CNT_W-1:0]     r_rxCnt;
    logic [BIT_W-1:0]     r_rxBit;
    logic [DATA_BITS-1:0] r_rxShift;
    logic                 r_frameErr;
    logic                 r_overrun;
    logic                 w_rxFull;
    logic                 w_rxEmpty;
    logic                 w_stopSample;
    logic                 w_rxPush;
`ifdef UART_PARITY_EN
    logic                 r_txParity;
    logic                 r_parBad;
    logic                 r_parityErr;
`endif

    assign tx_ready = r_outOfReset && !w_txFull;
    assign tx_busy  = !w_txEmpty || (r_txState != TX_IDLE);
    assign tx       = r_tx;
    assign w_txPop  = (r_txState == TX_IDLE) && !w_txEmpty;

    assign w_stopSample = (r_rxState == RX_STOP) && (r_rxCnt == CNT_LAST);
`ifdef UART_PARITY_EN
    assign w_rxPush      = w_stopSample && r_rxSync && !r_parBad;
    assign rx_parity_err = r_parityErr;
`else
    assign w_rxPush      = w_stopSample && r_rxSync;
    assign rx_parity_err = 1'b0;
`endif
    assign rx_valid     = !w_rxEmpty;
    assign rx_frame_err = r_frameErr;
    assign rx_overrun   = r_overrun;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_txFifo (
        .clk(clk), .rstn(rstn),
        .i_push(tx_valid && tx_ready), .i_data(tx_data), .i_pop(w_txPop),
        .o_data(w_txHead), .o_full(w_txFull), .o_empty(w_txEmpty)
    );

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rxFifo (
        .clk(clk), .rstn(rstn),
        .i_push(w_rxPush), .i_data(r_rxShift), .i_pop(rx_ready),
        .o_data(rx_data), .o_full(w_rxFull), .o_empty(w_rxEmpty)
    );

    // Holds tx_ready low until the first clock after reset releases.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_outOfReset <= 1'b0;
        end else begin
            r_outOfReset <= 1'b1;
        end
    end

    // tx is registered one cycle behind the state, so IDLE itself keeps the line high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_txState <= TX_IDLE;
            r_txCnt   <= '0;
            r_txBit   <= '0;
            r_txShift <= '0;
            r_tx      <= 1'b1;
`ifdef UART_PARITY_EN
            r_txParity <= 1'b0;
`endif
        end else begin
            case (r_txState)
                TX_IDLE: begin
                    r_tx    <= 1'b1;
                    r_txCnt <= '0;
                    r_txBit <= '0;
                    if (!w_txEmpty) begin
                        r_txShift <= w_txHead;
`ifdef UART_PARITY_EN
                        r_txParity <= evenParity(9'(w_txHead));
`endif
                        r_txState <= TX_START;
                    end
                end
                TX_START: begin
                    r_tx <= 1'b0;
                    if (r_txCnt == CNT_LAST) begin
                        r_txCnt   <= '0;
                        r_txState <= TX_DATA;
                    end else begin
                        r_txCnt <= r_txCnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    r_tx <= r_txShift[0];
                    if (r_txCnt == CNT_LAST) begin
                        r_txCnt   <= '0;
                        r_txShift <= r_txShift >> 1;
                        if (r_txBit == BIT_LAST) begin
                            r_txBit <= '0;
`ifdef UART_PARITY_EN
                            r_txState <= TX_PARITY;
`else
                            r_txState <= TX_STOP;
`endif
                        end else begin
                            r_txBit <= r_txBit + 1'b1;
                        end
                    end else begin
                        r_txCnt <= r_txCnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                TX_PARITY: begin
                    r_tx <= r_txParity;
                    if (r_txCnt == CNT_LAST) begin
                        r_txCnt   <= '0;
                        r_txState <= TX_STOP;
                    end else begin
                        r_txCnt <= r_txCnt + 1'b1;
                    end
                end
`endif
                TX_STOP: begin
                    r_tx <= 1'b1;
                    if (r_txCnt == CNT_LAST) begin
                        r_txCnt   <= '0;
                        r_txState <= TX_IDLE;
                    end else begin
                        r_txCnt <= r_txCnt + 1'b1;
                    end
                end
                default: r_txState <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rxMeta <= 1'b1;
            r_rxSync <= 1'b1;
            r_rxPrev <= 1'b1;
        end else begin
            r_rxMeta <= rx;
            r_rxSync <= r_rxMeta;
            r_rxPrev <= r_rxSync;
        end
    end

    // Start bit is checked at its midpoint; later bits are sampled one full period apart.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rxState  <= RX_IDLE;
            r_rxCnt    <= '0;
            r_rxBit    <= '0;
            r_rxShift  <= '0;
            r_frameErr <= 1'b0;
            r_overrun  <= 1'b0;
`ifdef UART_PARITY_EN
            r_parBad    <= 1'b0;
            r_parityErr <= 1'b0;
`endif
        end else begin
            r_frameErr <= 1'b0;
            r_overrun  <= 1'b0;
`ifdef UART_PARITY_EN
            r_parityErr <= 1'b0;
`endif
            case (r_rxState)
                RX_IDLE: begin
                    r_rxCnt <= '0;
                    r_rxBit <= '0;
                    if (r_rxPrev && !r_rxSync) begin
                        r_rxState <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rxCnt == CNT_HALF) begin
                        r_rxCnt   <= '0;
                        r_rxState <= r_rxSync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rxCnt <= r_rxCnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_rxCnt == CNT_LAST) begin
                        r_rxCnt   <= '0;
                        r_rxShift <= {r_rxSync, r_rxShift[DATA_BITS-1:1]};
                        if (r_rxBit == BIT_LAST) begin
                            r_rxBit <= '0;
`ifdef UART_PARITY_EN
                            r_rxState <= RX_PARITY;
`else
                            r_rxState <= RX_STOP;
`endif
                        end else begin
                            r_rxBit <= r_rxBit + 1'b1;
                        end
                    end else begin
                        r_rxCnt <= r_rxCnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (r_rxCnt == CNT_LAST) begin
                        r_rxCnt   <= '0;
                        r_parBad  <= (evenParity(9'(r_rxShift)) != r_rxSync);
                        r_rxState <= RX_STOP;
                    end else begin
                        r_rxCnt <= r_rxCnt + 1'b1;
                    end
                end
`endif
                RX_STOP: begin
                    if (r_rxCnt == CNT_LAST) begin
                        r_rxCnt   <= '0;
                        r_rxState <= RX_IDLE;
                        if (!r_rxSync) begin
                            r_frameErr <= 1'b1;
                        end
`ifdef UART_PARITY_EN
                        else if (r_parBad) begin
                            r_parityErr <= 1'b1;
                        end
`endif
                        else if (w_rxFull && !rx_ready) begin
                            r_overrun <= 1'b1;
                        end
`ifdef UART_PARITY_EN
                        r_parBad <= 1'b0;
`endif
                    end else begin
                        r_rxCnt <= r_rxCnt + 1'b1;
                    end
                end
                default: r_rxState <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core with 16-cycle bits, 8 data bits and 4-entry FIFOs.
// Parity-specific steps compile in when UART_PARITY_EN is defined.
module tb_uart_core;

    localparam int CPP     = 16;
    localparam int DB      = 8;
    localparam int DEPTH   = 4;
    localparam int TRACE_N = 200;
`ifdef UART_PARITY_EN
    localparam int FRAME_N = 11;
`else
    localparam int FRAME_N = 10;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic [DB-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx;
    logic          tx_busy;
    logic          rx;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          rx_frame_err;
    logic          rx_parity_err;
    logic          rx_overrun;

    logic          loopback;
    logic          rxDrive;

    int totalChecks = 0;
    int badChecks   = 0;
    int frameErrPulses  = 0;
    int parityErrPulses = 0;
    int overrunPulses   = 0;

    logic txTrace   [0:TRACE_N];
    logic busyTrace [0:TRACE_N];

    assign rx = loopback ? tx : rxDrive;

    always #5 clk = ~clk;

    uart_core #(
        .CLOCKS_PER_PULSE(CPP),
        .DATA_BITS(DB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx(tx),
        .tx_busy(tx_busy),
        .rx(rx),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .rx_frame_err(rx_frame_err),
        .rx_parity_err(rx_parity_err),
        .rx_overrun(rx_overrun)
    );

    always @(negedge clk) begin
        if (rx_frame_err === 1'b1) frameErrPulses++;
        if (rx_parity_err === 1'b1) parityErrPulses++;
        if (rx_overrun === 1'b1) overrunPulses++;
    end

    initial begin
        repeat (20000) @(negedge clk);
        $display("[TB] FAIL watchdog expired before the directed sequence finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        assert (observed === expected) else begin
            badChecks++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives a frame onto rx from a negedge, LSB (start bit) first, then returns the line high.
    task automatic applyStimulus(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rxDrive = bits[i];
            repeat (CPP) @(negedge clk);
        end
        rxDrive = 1'b1;
    endtask

    function automatic logic [10:0] buildFrame(input logic [7:0] d, input logic stopBit);
`ifdef UART_PARITY_EN
        return {stopBit, ^d, d, 1'b0};
`else
        return {1'b0, stopBit, d, 1'b0};
`endif
    endfunction

    initial begin
        logic [7:0] expByte;
        logic [7:0] expWords [3];
        logic [7:0] ovWords [5];
        int         baseFrame;
        int         baseParity;
        int         baseOverrun;

        rstn     = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        loopback = 1'b0;
        rxDrive  = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("reset_tx", tx, 1'b1);
        checkOutput("reset_tx_busy", tx_busy, 1'b0);
        checkOutput("reset_tx_ready", tx_ready, 1'b0);
        checkOutput("reset_rx_valid", rx_valid, 1'b0);
        checkOutput("reset_rx_data", rx_data, 8'h00);
        checkOutput("reset_err_pulses", {rx_frame_err, rx_parity_err, rx_overrun}, 3'b000);

        rstn = 1'b1;
        @(negedge clk);
        checkOutput("tx_ready_after_reset", tx_ready, 1'b1);

        // Single 0xA5 frame: capture tx per cycle relative to the accepting edge.
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        txTrace[0]   = tx;
        busyTrace[0] = tx_busy;
        for (int p = 1; p <= TRACE_N; p++) begin
            @(negedge clk);
            txTrace[p]   = tx;
            busyTrace[p] = tx_busy;
        end
        checkOutput("tx_idle_p0", txTrace[0], 1'b1);
        checkOutput("tx_idle_p1", txTrace[1], 1'b1);
        checkOutput("tx_start_p2", txTrace[2], 1'b0);
        checkOutput("tx_start_last_p17", txTrace[17], 1'b0);
        checkOutput("tx_bit0_first_p18", txTrace[18], 1'b1);
        expByte = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("tx_bit%0d_mid", k), txTrace[18 + 16*k + 8], expByte[k]);
        end
        checkOutput("tx_stop_mid", txTrace[2 + 16*(FRAME_N-1) + 8], 1'b1);
        checkOutput("tx_busy_p0", busyTrace[0], 1'b1);
        checkOutput("tx_busy_last", busyTrace[FRAME_N*16], 1'b1);
        checkOutput("tx_busy_done", busyTrace[FRAME_N*16 + 1], 1'b0);

        // Loopback of three back-to-back words.
        baseFrame   = frameErrPulses;
        baseParity  = parityErrPulses;
        baseOverrun = overrunPulses;
        loopback    = 1'b1;
        expWords[0] = 8'h00;
        expWords[1] = 8'hFF;
        expWords[2] = 8'h3C;
        tx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_data = expWords[i];
            @(negedge clk);
        end
        tx_valid = 1'b0;
        repeat (3*(FRAME_N*16 + 1) + 60) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("loop_valid%0d", i), rx_valid, 1'b1);
            checkOutput($sformatf("loop_data%0d", i), rx_data, expWords[i]);
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
        checkOutput("loop_drained", rx_valid, 1'b0);
        checkOutput("loop_no_errors", (frameErrPulses - baseFrame) + (parityErrPulses - baseParity) + (overrunPulses - baseOverrun), 0);
        loopback = 1'b0;
        repeat (4) @(negedge clk);

        // Short low glitch must be rejected silently.
        baseFrame = frameErrPulses;
        rxDrive = 1'b0;
        repeat (5) @(negedge clk);
        rxDrive = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("glitch_no_push", rx_valid, 1'b0);
        checkOutput("glitch_no_frame_err", frameErrPulses - baseFrame, 0);

        // 0x55 with a low stop bit.
        baseFrame = frameErrPulses;
        applyStimulus(buildFrame(8'h55, 1'b0), FRAME_N);
        repeat (20) @(negedge clk);
        checkOutput("frame_err_once", frameErrPulses - baseFrame, 1);
        checkOutput("frame_err_no_push", rx_valid, 1'b0);

        // FIFO_DEPTH+1 good frames with no consumer.
        baseFrame   = frameErrPulses;
        baseOverrun = overrunPulses;
        ovWords[0] = 8'h11;
        ovWords[1] = 8'h22;
        ovWords[2] = 8'h33;
        ovWords[3] = 8'h44;
        ovWords[4] = 8'h55;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(buildFrame(ovWords[i], 1'b1), FRAME_N);
        end
        repeat (20) @(negedge clk);
        checkOutput("overrun_once", overrunPulses - baseOverrun, 1);
        checkOutput("overrun_no_frame_err", frameErrPulses - baseFrame, 0);
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput($sformatf("overrun_valid%0d", i), rx_valid, 1'b1);
            checkOutput($sformatf("overrun_data%0d", i), rx_data, ovWords[i]);
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
        checkOutput("overrun_drained", rx_valid, 1'b0);

`ifdef UART_PARITY_EN
        // 0x07 has three ones, so even parity is 1; send 0 instead.
        baseParity = parityErrPulses;
        applyStimulus({1'b1, 1'b0, 8'h07, 1'b0}, 11);
        repeat (20) @(negedge clk);
        checkOutput("parity_err_once", parityErrPulses - baseParity, 1);
        checkOutput("parity_word_dropped", rx_valid, 1'b0);
`else
        checkOutput("parity_err_never", parityErrPulses, 0);
`endif

        // Reset in the middle of the start bit.
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("midframe_tx_low", tx, 1'b0);
        rstn = 1'b0;
        #1;
        checkOutput("midframe_reset_tx", tx, 1'b1);
        checkOutput("midframe_reset_ready", tx_ready, 1'b0);
        checkOutput("midframe_reset_busy", tx_busy, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("midframe_ready_rises", tx_ready, 1'b1);
        repeat (30) @(negedge clk);
        checkOutput("midframe_tx_stays_high", tx, 1'b1);
        checkOutput("midframe_not_busy", tx_busy, 1'b0);
        checkOutput("midframe_no_rx_word", rx_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
